// File: rtl/dds_multi_wave.sv
`default_nettype none
// ============================================================================
// Module   : dds_multi_wave
// Brief    : Multi-waveform DDS channel with external registered ROM, glitch-free
//            FCW update at phase wrap, noise LFSR, amplitude scaling and enable.
// Revision : 1.0
// ============================================================================
module dds_multi_wave #(
    parameter int          PHASE_W   = 32,
    parameter int          ADDR_W    = 8,
    parameter int          DATA_W    = 8,
    parameter logic [15:0] LFSR_SEED = 16'h0001
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               dds_en,
    input  logic               phase_rst,
    input  logic [PHASE_W-1:0] fcw,
    input  logic               fcw_load,
    input  logic [2:0]         wave_sel,
    input  logic [DATA_W-1:0]  amp,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [DATA_W-1:0]  rom_data,
    output logic [DATA_W-1:0]  q,
    output logic               q_valid
);

    localparam int PROD_W = 2 * DATA_W + 1;

    logic [PHASE_W-1:0] r_acc;
    logic [PHASE_W-1:0] r_fcw_act;
    logic [PHASE_W-1:0] r_fcw_pend;
    logic               r_pend_flag;
    logic [15:0]        r_lfsr;

    logic [ADDR_W-1:0]  r_addr_d1;
    logic [DATA_W-1:0]  r_noise_d1;
    logic [2:0]         r_sel_d1;
    logic               r_en_d1;

    logic [PHASE_W:0]   w_sum;
    logic               w_wrap;
    logic               w_apply;
    logic               w_lfsr_fb;
    logic [ADDR_W-1:0]  w_gen;
    logic [DATA_W-1:0]  w_wave;
    logic [DATA_W:0]    w_amp_p1;
    logic [PROD_W-1:0]  w_prod;

    assign w_sum     = {1'b0, r_acc} + {1'b0, r_fcw_act};
    // phase_rst suppresses the wrap so it never double-applies or steps noise
    assign w_wrap    = dds_en & ~phase_rst & w_sum[PHASE_W];
    assign w_apply   = w_wrap | phase_rst | ~dds_en;
    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign rom_addr  = r_acc[PHASE_W-1 -: ADDR_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_fcw_act   <= '0;
            r_fcw_pend  <= '0;
            r_pend_flag <= 1'b0;
            r_lfsr      <= LFSR_SEED;
        end else begin
            if (phase_rst) begin
                r_acc <= '0;
            end else if (dds_en) begin
                r_acc <= w_sum[PHASE_W-1:0];
            end
            if (w_apply && r_pend_flag) begin
                r_fcw_act <= r_fcw_pend;
            end
            if (fcw_load) begin
                r_fcw_pend  <= fcw;
                r_pend_flag <= 1'b1;
            end else if (w_apply) begin
                r_pend_flag <= 1'b0;
            end
            if (w_wrap) begin
                r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
            end
        end
    end

    // S1: aligned with the registered ROM output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr_d1  <= '0;
            r_noise_d1 <= '0;
            r_sel_d1   <= '0;
            r_en_d1    <= 1'b0;
        end else begin
            r_addr_d1  <= rom_addr;
            r_noise_d1 <= r_lfsr[15 -: DATA_W];
            r_sel_d1   <= wave_sel;
            r_en_d1    <= dds_en;
        end
    end

    always_comb begin
        w_gen  = '0;
        w_wave = '0;
        case (r_sel_d1)
            3'd1:    w_gen = {ADDR_W{r_addr_d1[ADDR_W-1]}};
            3'd2:    w_gen = r_addr_d1;
            3'd3:    w_gen = {r_addr_d1[ADDR_W-2:0] ^ {(ADDR_W-1){r_addr_d1[ADDR_W-1]}}, 1'b0};
            default: w_gen = '0;
        endcase
        case (r_sel_d1)
            3'd0:                 w_wave = rom_data;
            3'd1, 3'd2, 3'd3:     w_wave = DATA_W'(w_gen) << (DATA_W - ADDR_W);
            3'd4:                 w_wave = r_noise_d1;
            default:              w_wave = '0;
        endcase
    end

    // amp+1 makes all-ones an exact unity gain after the DATA_W shift
    assign w_amp_p1 = {1'b0, amp} + (DATA_W + 1)'(1);
    assign w_prod   = PROD_W'(w_wave) * PROD_W'(w_amp_p1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q       <= '0;
            q_valid <= 1'b0;
        end else begin
            q       <= r_en_d1 ? w_prod[2*DATA_W-1:DATA_W] : '0;
            q_valid <= r_en_d1;
        end
    end

endmodule
`default_nettype wire
